dmem_responder: RTL and testbench

- Memory-side responder for CPU data-memory accesses: accepts one read/write request at a time over a valid/ready channel.
- Inserts a programmable number of wait states, performs the access on an internal word array, then returns a response over a second valid/ready channel.
- Sits between the core's load/store port (address = ALU result, store data = register read port 2) and backing storage.
- Lets the core and bench exercise multi-cycle memory instead of a combinational array.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: one request in flight, LATENCY wait states, valid/ready response.
// Optional misaligned-access trap enabled by defining DMEM_RESPONDER_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int n       = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    output logic         busy
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         AW       = IDX_W + 2;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [n-1:0]  r_wdata;
    logic [n-1:0]  r_rdata;
    logic          r_err;
    logic          r_valid;
    logic [n-1:0]  r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic          w_c_we;
    logic [AW-1:0] w_c_addr;
    logic [n-1:0]  w_c_wdata;
    logic          w_misalign;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]    w_state_nxt;

    // With zero wait states the access commits straight from the request inputs on the accept edge.
    always_comb begin
        w_accept = req_valid & (r_state == S_IDLE);
        if (LATENCY == 0) begin
            w_commit  = w_accept;
            w_c_we    = req_we;
            w_c_addr  = req_addr[AW-1:0];
            w_c_wdata = req_wdata;
        end else begin
            w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0);
            w_c_we    = r_we;
            w_c_addr  = r_addr;
            w_c_wdata = r_wdata;
        end
        w_idx = w_c_addr[AW-1:2];
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        w_misalign = |w_c_addr[1:0];
`else
        w_misalign = 1'b0;
`endif
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM, request holding registers and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr[AW-1:0];
                r_wdata <= req_wdata;
                r_err   <= 1'b0;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Commit is placed after accept so a zero-latency error flag overrides the accept clear.
            if (w_commit) begin
                r_valid <= 1'b1;
                if (w_misalign) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (w_c_we) begin
                    r_rdata <= w_c_wdata;
                    r_err   <= 1'b0;
                end else begin
                    r_rdata <= r_mem[w_idx];
                    r_err   <= 1'b0;
                end
            end else if ((r_state == S_RESP) && resp_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Word array, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_c_we && !w_misalign) begin
            r_mem[w_idx] <= w_c_wdata;
        end
    end

    assign req_ready  = (r_state == S_IDLE) & ~rst;
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = r_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: LATENCY=2 main instance plus a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, resp_ready0 = 1'b1;
    logic [31:0] req_addr0 = 32'd0, req_wdata0 = 32'd0;
    logic        req_ready0, resp_valid0, resp_err0, busy0;
    logic [31:0] resp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? req_ready0 : req_ready;
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? resp_valid0 : resp_valid;
    endfunction

    // One transaction: expected response is queued at drive time and popped when the response shows up.
    task automatic txn(input bit sel, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input bit exp_e, input int stall);
        int w;
        int lat;
        logic [32:0] e;
        lat = sel ? 0 : 2;
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        if (sel) begin
            req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata;
            resp_ready0 = 1'b1;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
            resp_ready = (stall == 0);
        end
        w = 0;
        while (!rdy(sel) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_before_accept", {31'd0, rdy(sel)}, 32'd1);
        @(negedge clk);
        req_valid0 = 1'b0;
        req_valid  = 1'b0;
        w = 1;
        while (!vld(sel) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("latency_edges", w, lat + 1);
        e = exp_q.pop_front();
        chk("resp_rdata", sel ? resp_rdata0 : resp_rdata, e[31:0]);
        chk("resp_err", {31'd0, sel ? resp_err0 : resp_err}, {31'd0, e[32]});
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_0040;
            @(negedge clk);
            chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata_hold", resp_rdata, e[31:0]);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("resp_valid_cleared", {31'd0, vld(sel)}, 32'd0);
        chk("busy_after_handshake", {31'd0, sel ? busy0 : busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] mis_d, word_d;
        bit          mis_e;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        mis_d = 32'h0000_0000; mis_e = 1'b1; word_d = 32'h1111_2222;
`else
        mis_d = 32'hA5A5_A5A5; mis_e = 1'b0; word_d = 32'hA5A5_A5A5;
`endif
        // Reset held for two cycles.
        @(negedge clk);
        chk("rst_req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);

        txn(1'b0, 1'b0, 32'h0000_0000, 32'd0, 32'h0000_0000, 1'b0, 0);
        txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
        txn(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
        txn(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 5);

        // Aliasing modulo DEPTH*4 bytes.
        txn(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        txn(1'b0, 1'b0, 32'h0000_0004, 32'd0, 32'h1234_5678, 1'b0, 0);

        // Reset during WAIT drops the pending write and the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_busy_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        txn(1'b0, 1'b0, 32'h0000_0020, 32'd0, 32'h0000_0000, 1'b0, 0);

        // Misaligned write to 0x22 against word 0x20.
        txn(1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'h1111_2222, 1'b0, 0);
        txn(1'b0, 1'b1, 32'h0000_0022, 32'hA5A5_A5A5, mis_d, mis_e, 0);
        txn(1'b0, 1'b0, 32'h0000_0020, 32'd0, word_d, 1'b0, 0);

        // Zero-latency instance.
        txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h0000_0000, 1'b0, 0);
        txn(1'b1, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 0);
        txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h55AA_55AA, 1'b0, 0);
        txn(1'b1, 1'b1, 32'h0000_0022, 32'h0F0F_0F0F, mis_e ? 32'h0 : 32'h0F0F_0F0F, mis_e, 0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
